// File: rtl/ram_descramble_reader.sv
// Sequential reader for an asynchronous SRAM: walks START_ADDR..END_ADDR and
// presents each byte, with its bit order restored, behind a valid/ready handshake.
module ram_descramble_reader #(
  parameter int                 ADDR_W     = 5,
  parameter logic [ADDR_W-1:0]  START_ADDR = 'h04,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 'h1E
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CS_ram,
  output logic              OE_ram,
  output logic              WS_ram,
  input  logic [7:0]        DATA_ram,
  output logic [7:0]        DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic              cs_reg, cs_next;
  logic              oe_reg, oe_next;
  logic              valid_reg, valid_next;
  logic              done_reg, done_next;
  logic [7:0]        descr;

  // Undo the write-side interleave: low output nibble takes odd bits
  // high-to-low, high output nibble takes even bits low-to-high.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_descr
      if (gi < 4) begin : g_lo
        assign descr[gi] = DATA_ram[7-2*gi];
      end else begin : g_hi
        assign descr[gi] = DATA_ram[2*gi-8];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          addr_next  = START_ADDR;
          state_next = (START_ADDR > END_ADDR) ? ST_FINISH : ST_SETUP;
        end
      end
      ST_SETUP:  state_next = ST_SAMPLE;
      ST_SAMPLE: begin
        data_next  = descr;
        state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        // Test for the last address before incrementing so an all-ones
        // END_ADDR never wraps the counter back to zero.
        if (DOUT_READY) begin
          if (addr_reg == END_ADDR) begin
            state_next = ST_FINISH;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = ST_SETUP;
          end
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so the RAM pins never glitch.
  always_comb begin
    cs_next    = 1'b1;
    oe_next    = 1'b0;
    valid_next = 1'b0;
    done_next  = 1'b0;
    case (state_next)
      ST_SETUP, ST_SAMPLE: begin
        cs_next = 1'b0;
        oe_next = 1'b1;
      end
      ST_OUTPUT: valid_next = 1'b1;
      ST_FINISH: done_next  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      data_reg  <= 8'h00;
      cs_reg    <= 1'b1;
      oe_reg    <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      cs_reg    <= cs_next;
      oe_reg    <= oe_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  assign ADDR       = addr_reg;
  assign DOUT       = data_reg;
  assign CS_ram     = cs_reg;
  assign OE_ram     = oe_reg;
  assign WS_ram     = 1'b0;
  assign DOUT_VALID = valid_reg;
  assign DONE       = done_reg;
  assign BUSY       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ram_descramble_reader.sv
// Directed bench for ram_descramble_reader: default range, a single-address
// range at the top of memory, and an empty (reversed) range.
module tb_ram_descramble_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       start0, start1, start2;
  logic [4:0] addr0, addr1, addr2;
  logic       cs0, cs1, cs2, oe0, oe1, oe2, ws0, ws1, ws2;
  logic [7:0] data0, data1, data2, dout0, dout1, dout2;
  logic       valid0, valid1, valid2, busy0, busy1, busy2, done0, done1, done2;

  logic [7:0] ram     [32];
  logic [7:0] exp_mem [32];

  typedef struct {
    logic [4:0] addr;
    logic [7:0] raw;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [12];

  int n_checks = 0;
  int n_fail   = 0;
  int cs_low0 = 0, cs_low1 = 0, cs_low2 = 0;

  always #5 clk = ~clk;

  assign data0 = ram[addr0];
  assign data1 = ram[addr1];
  assign data2 = ram[addr2];

  ram_descramble_reader u0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .ADDR(addr0), .CS_ram(cs0), .OE_ram(oe0),
    .WS_ram(ws0), .DATA_ram(data0), .DOUT(dout0), .DOUT_VALID(valid0),
    .DOUT_READY(ready), .BUSY(busy0), .DONE(done0));

  ram_descramble_reader #(.ADDR_W(5), .START_ADDR(5'h1F), .END_ADDR(5'h1F)) u1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .ADDR(addr1), .CS_ram(cs1), .OE_ram(oe1),
    .WS_ram(ws1), .DATA_ram(data1), .DOUT(dout1), .DOUT_VALID(valid1),
    .DOUT_READY(ready), .BUSY(busy1), .DONE(done1));

  ram_descramble_reader #(.ADDR_W(5), .START_ADDR(5'h05), .END_ADDR(5'h04)) u2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .ADDR(addr2), .CS_ram(cs2), .OE_ram(oe2),
    .WS_ram(ws2), .DATA_ram(data2), .DOUT(dout2), .DOUT_VALID(valid2),
    .DOUT_READY(ready), .BUSY(busy2), .DONE(done2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d);
    model = {d[6], d[4], d[2], d[0], d[1], d[3], d[5], d[7]};
  endfunction

  // RAM access counters: one tick per rising edge with the chip selected.
  always @(posedge clk) begin
    if (!cs0) cs_low0++;
    if (!cs1) cs_low1++;
    if (!cs2) cs_low2++;
  end

  // Pin protocol on every cycle for all three instances.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ws0_low", ws0, 0);
      check("oe0_cs0", oe0 & (cs0 | ws0), 0);
      check("ws1_low", ws1, 0);
      check("oe1_cs1", oe1 & (cs1 | ws1), 0);
      check("ws2_low", ws2, 0);
      check("oe2_cs2", oe2 & (cs2 | ws2), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx, cyc, c0, n;
    logic [7:0] held;

    vecs[0]  = '{5'd4,  8'h80, 8'h01};
    vecs[1]  = '{5'd5,  8'h01, 8'h10};
    vecs[2]  = '{5'd6,  8'h00, 8'h00};
    vecs[3]  = '{5'd7,  8'hFF, 8'hFF};
    vecs[4]  = '{5'd8,  8'h40, 8'h80};
    vecs[5]  = '{5'd9,  8'h02, 8'h08};
    vecs[6]  = '{5'd10, 8'h0F, 8'h3C};
    vecs[7]  = '{5'd11, 8'hF0, 8'hC3};
    vecs[8]  = '{5'd12, 8'h55, 8'hF0};
    vecs[9]  = '{5'd13, 8'hAA, 8'h0F};
    vecs[10] = '{5'd14, 8'h10, 8'h40};
    vecs[11] = '{5'd15, 8'h20, 8'h02};

    for (int a = 0; a < 32; a++) begin
      ram[a]     = 8'(a * 37 + 3);
      exp_mem[a] = model(ram[a]);
    end
    for (int k = 0; k < 12; k++) begin
      ram[vecs[k].addr]     = vecs[k].raw;
      exp_mem[vecs[k].addr] = vecs[k].exp;
    end
    ram[31]     = 8'h40;
    exp_mem[31] = 8'h80;

    rst_n = 1'b0; ready = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_u0", {addr0, cs0, oe0, ws0, dout0, valid0, busy0, done0}, {5'd0, 3'b100, 8'h00, 3'b000});
    check("reset_u1", {addr1, cs1, oe1, dout1, valid1, busy1, done1}, {5'd0, 2'b10, 8'h00, 3'b000});
    check("reset_u2", {addr2, cs2, oe2, dout2, valid2, busy2, done2}, {5'd0, 2'b10, 8'h00, 3'b000});
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy0, cs0, oe0, valid0}, 4'b0100);

    // Full pass at full rate, with a stray START while busy at cycle 7.
    c0 = cs_low0;
    start0 = 1'b1;
    @(posedge clk);
    idx = 0; cyc = 0;
    while (idx < 27 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start0 = (cyc == 7);
      if (valid0) begin
        $display("u0 pass addr=%0d dout=%02h cycle=%0d", addr0, dout0, cyc);
        check("pass_addr", addr0, 4 + idx);
        check("pass_dout", dout0, exp_mem[4+idx]);
        check("pass_cycle", cyc, 3 + 3 * idx);
        idx++;
      end
    end
    check("pass_count", idx, 27);
    @(negedge clk);
    check("pass_done", {done0, busy0, addr0}, {2'b11, 5'd30});
    @(negedge clk);
    check("pass_done_end", {done0, busy0, addr0}, {2'b00, 5'd30});
    check("pass_reads", cs_low0 - c0, 54);
    repeat (3) @(negedge clk);
    check("no_queued_pass", {busy0, done0}, 2'b00);

    // Backpressure at address 7, then reset mid-pass at address 10.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!(valid0 && addr0 == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach7", {valid0, addr0}, {1'b1, 5'd7});
    ready = 1'b0;
    held = dout0;
    c0 = cs_low0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold", {valid0, cs0, oe0, addr0, dout0}, {3'b110, 5'd7, held});
    end
    check("bp_dout", held, 8'hFF);
    check("bp_no_access", cs_low0 - c0, 0);
    ready = 1'b1;
    @(negedge clk);
    check("bp_resume", {valid0, cs0, oe0, addr0}, {3'b001, 5'd8});
    n = 0;
    while (!(valid0 && addr0 == 5'd10) && n < 100) begin
      if (valid0) begin
        $display("u0 resume addr=%0d dout=%02h", addr0, dout0);
        check("resume_dout", dout0, exp_mem[addr0]);
      end
      @(negedge clk);
      n++;
    end
    check("rst_reach10", {valid0, addr0, dout0}, {1'b1, 5'd10, 8'h3C});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {addr0, cs0, oe0, ws0, dout0, valid0, busy0, done0}, {5'd0, 3'b100, 8'h00, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", {busy0, done0}, 2'b00);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (!valid0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    $display("u0 restart addr=%0d dout=%02h", addr0, dout0);
    check("restart_addr", addr0, 4);
    check("restart_dout", dout0, 8'h01);
    n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("restart_done", done0, 1);

    // Single-address range at the top of memory.
    c0 = cs_low1;
    idx = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 20) begin
      if (valid1) begin
        $display("u1 addr=%0d dout=%02h", addr1, dout1);
        check("top_dout", {addr1, dout1}, {5'd31, 8'h80});
        idx++;
      end
      @(negedge clk);
      n++;
    end
    check("top_done", {done1, addr1}, {1'b1, 5'd31});
    check("top_count", idx, 1);
    check("top_reads", cs_low1 - c0, 2);
    @(negedge clk);
    check("top_idle", {busy1, done1, addr1}, {2'b00, 5'd31});

    // Reversed range: straight to FINISH without touching the RAM.
    c0 = cs_low2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    $display("u2 empty range done=%0b busy=%0b", done2, busy2);
    check("empty_done", {done2, busy2, valid2}, 3'b110);
    @(negedge clk);
    check("empty_idle", {done2, busy2, valid2}, 3'b000);
    check("empty_reads", cs_low2 - c0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
